// File: rtl/trivium_pkg.sv
// Shared types and constants for the Trivium core sequencing controller.
package trivium_pkg;

  // Key width of the cipher core.
  localparam int unsigned KEY_W = 80;

  // Width of the shared down-counter used for the init and response timeouts.
  localparam int unsigned TMR_W = 16;

  // Controller states; the encoding is visible on ctrl_state.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_KEY  = 3'd1,
    ST_WAIT_INIT = 3'd2,
    ST_RUN       = 3'd3,
    ST_HOLD      = 3'd4,
    ST_FAULT     = 3'd5
  } ctrl_state_e;

  // Bit positions inside core_status.
  localparam int unsigned STAT_RUNNING   = 0;
  localparam int unsigned STAT_BLK_FULL  = 1;
  localparam int unsigned STAT_ERR       = 2;
  localparam int unsigned STAT_KEY_ERR   = 3;
  localparam int unsigned STAT_TOT_RESET = 4;

  // Flow status reported to the core; the upper bit is never used.
  localparam logic [1:0] FIFO_CND_OPEN = 2'b00;
  localparam logic [1:0] FIFO_CND_BUSY = 2'b01;

  function automatic logic [1:0] fifo_cnd_enc(input logic busy);
    return busy ? FIFO_CND_BUSY : FIFO_CND_OPEN;
  endfunction

endpackage

// File: rtl/trivium_key_ser.sv
// Key serializer: captures the full key, then presents it MSB first with a
// strobe held for STROBE_LEN cycles. Bits beyond the key width shift out as 0.
module trivium_key_ser
  import trivium_pkg::*;
#(
  parameter int unsigned STROBE_LEN = 81
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [KEY_W-1:0] key_i,
  output logic             strobe_o,
  output logic             key_bit_o,
  output logic             last_o
);

  localparam int unsigned CNT_W = $clog2(STROBE_LEN + 1);

  logic [KEY_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Shift register and remaining-strobe counter, cleared asynchronously so the
  // strobe drops the moment reset asserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load takes priority; otherwise shift left with zero fill while strobing.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = key_i;
      cnt_d   = CNT_W'(STROBE_LEN);
    end else if (cnt_q != '0) begin
      shift_d = {shift_q[KEY_W-2:0], 1'b0};
      cnt_d   = cnt_q - 1'b1;
    end
  end

  assign strobe_o  = (cnt_q != '0);
  assign key_bit_o = strobe_o & shift_q[KEY_W-1];
  assign last_o    = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/trivium_ctrl.sv
// Sequencing controller for a Trivium stream-cipher core: loads the key
// serially, waits for core init, then moves plaintext bytes into the core one
// at a time and buffers each ciphertext byte for the downstream consumer.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  IDLE       | after reset, waiting for the first key_load
//  LOAD_KEY   | key strobed into core bit by bit (key_load ignored)
//  WAIT_INIT  | waiting for core running bit, bounded by INIT_TIMEOUT
//  RUN        | one byte at a time: issue, await core_wt_sgn, buffer
//  HOLD       | core block-full; no issue until running bit returns
//  FAULT      | sticky fault, only key_load leaves
module trivium_ctrl
  import trivium_pkg::*;
#(
  parameter int unsigned KEY_STROBE_LEN = 81,
  parameter int unsigned INIT_TIMEOUT   = 2047,
  parameter int unsigned RSP_TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  input  logic             ds_afull,
  output logic             core_key,
  output logic             core_strob_key,
  output logic [7:0]       core_data,
  output logic             core_strob_data,
  output logic [1:0]       core_fifo_cnd,
  input  logic [7:0]       core_stream,
  input  logic             core_wt_sgn,
  input  logic [7:0]       core_status,
  output logic [2:0]       ctrl_state,
  output logic             fault,
  output logic [15:0]      byte_cnt
);

  localparam logic [TMR_W-1:0] INIT_TMR = TMR_W'(INIT_TIMEOUT);
  localparam logic [TMR_W-1:0] RSP_TMR  = TMR_W'(RSP_TIMEOUT);

  ctrl_state_e      state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             outst_q, outst_d;
  logic             ob_valid_q, ob_valid_d;
  logic [7:0]       ob_data_q, ob_data_d;
  logic [15:0]      byte_cnt_q, byte_cnt_d;
  logic             fault_q, fault_d;

  logic key_accept;
  logic issue;
  logic xfer;
  logic rsp_to;
  logic ser_strobe;
  logic ser_bit;
  logic ser_last;

  logic running, blk_full, err_any;
  logic unused_status;

  assign running  = core_status[STAT_RUNNING];
  assign blk_full = core_status[STAT_BLK_FULL];
  assign err_any  = core_status[STAT_ERR] | core_status[STAT_KEY_ERR]
                  | core_status[STAT_TOT_RESET];
  assign unused_status = ^core_status[7:5];

  trivium_key_ser #(
    .STROBE_LEN (KEY_STROBE_LEN)
  ) u_key_ser (
    .clk       (clk),
    .rst       (rst),
    .load_i    (key_accept),
    .key_i     (key_in),
    .strobe_o  (ser_strobe),
    .key_bit_o (ser_bit),
    .last_o    (ser_last)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Timer, outstanding flag, output buffer, byte counter and fault flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q      <= '0;
      outst_q    <= 1'b0;
      ob_valid_q <= 1'b0;
      ob_data_q  <= '0;
      byte_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      tmr_q      <= tmr_d;
      outst_q    <= outst_d;
      ob_valid_q <= ob_valid_d;
      ob_data_q  <= ob_data_d;
      byte_cnt_q <= byte_cnt_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state and datapath control. A key reload or a fault entry overrides
  // whatever the state branch decided about the byte pipeline.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    outst_d    = outst_q;
    ob_valid_d = ob_valid_q;
    ob_data_d  = ob_data_q;
    byte_cnt_d = byte_cnt_q;
    fault_d    = fault_q;
    key_accept = 1'b0;
    issue      = 1'b0;
    rsp_to     = 1'b0;

    xfer = ob_valid_q & out_ready;
    if (xfer) begin
      ob_valid_d = 1'b0;
      if (byte_cnt_q != 16'hFFFF) begin
        byte_cnt_d = byte_cnt_q + 16'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (key_load) begin
          key_accept = 1'b1;
        end
      end

      ST_LOAD_KEY: begin
        if (ser_last) begin
          state_d = ST_WAIT_INIT;
          tmr_d   = INIT_TMR;
        end
      end

      ST_WAIT_INIT: begin
        if (core_status[STAT_KEY_ERR]) begin
          state_d = ST_FAULT;
        end else if (running) begin
          state_d = ST_RUN;
        end else if (tmr_q <= TMR_W'(1)) begin
          state_d = ST_FAULT;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      ST_RUN, ST_HOLD: begin
        if (key_load) begin
          key_accept = 1'b1;
        end else if (err_any) begin
          state_d = ST_FAULT;
        end else begin
          // The response may land in either state; the timer keeps running in HOLD.
          if (outst_q) begin
            if (core_wt_sgn) begin
              outst_d    = 1'b0;
              ob_valid_d = 1'b1;
              ob_data_d  = core_stream;
            end else if (tmr_q <= TMR_W'(1)) begin
              rsp_to = 1'b1;
            end else begin
              tmr_d = tmr_q - TMR_W'(1);
            end
          end

          if (rsp_to) begin
            state_d = ST_FAULT;
          end else if (state_q == ST_RUN) begin
            if (blk_full) begin
              state_d = ST_HOLD;
            end else if (in_valid && !outst_q && !ob_valid_q && !ds_afull) begin
              issue   = 1'b1;
              outst_d = 1'b1;
              tmr_d   = RSP_TMR;
            end
          end else if (running) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_FAULT: begin
        if (key_load) begin
          key_accept = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_FAULT && state_q != ST_FAULT) begin
      fault_d    = 1'b1;
      outst_d    = 1'b0;
      ob_valid_d = 1'b0;
    end

    // A new key drops any byte in flight, including one whose result arrives now.
    if (key_accept) begin
      state_d    = ST_LOAD_KEY;
      byte_cnt_d = '0;
      outst_d    = 1'b0;
      ob_valid_d = 1'b0;
      fault_d    = 1'b0;
    end
  end

  // Outputs; reset gating on fifo_cnd keeps it at 00 while rst is low.
  always_comb begin
    in_ready        = issue;
    core_strob_data = issue;
    core_data       = issue ? in_data : 8'h00;
    core_strob_key  = ser_strobe & (state_q == ST_LOAD_KEY);
    core_key        = ser_bit & (state_q == ST_LOAD_KEY);
    core_fifo_cnd   = rst ? fifo_cnd_enc(ob_valid_q | ds_afull) : FIFO_CND_OPEN;
    out_valid       = ob_valid_q;
    out_data        = ob_data_q;
    ctrl_state      = state_q;
    fault           = fault_q;
    byte_cnt        = byte_cnt_q;
  end

endmodule

// File: tb/tb_trivium_ctrl.sv
module tb_trivium_ctrl;

  localparam logic [79:0] KEY_A      = 80'h0123456789ABCDEF0123;
  localparam logic [7:0]  KS_SEED    = 8'h5A;
  localparam int          INIT_DELAY = 1152;

  logic        clk = 1'b0;
  logic        rst, key_load;
  logic [79:0] key_in;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        ds_afull;
  logic        core_key, core_strob_key;
  logic [7:0]  core_data;
  logic        core_strob_data;
  logic [1:0]  core_fifo_cnd;
  logic [7:0]  core_stream = 8'h00;
  logic        core_wt_sgn = 1'b0;
  logic [7:0]  core_status = 8'h00;
  logic [2:0]  ctrl_state;
  logic        fault;
  logic [15:0] byte_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sb_q[$];
  logic [7:0] exp_ks;

  // core model controls and state
  bit         m_never_init = 1'b0, m_no_rsp = 1'b0, m_blk = 1'b0;
  bit         m_keyed = 1'b0, m_pend = 1'b0;
  int         m_init_cnt = 0, m_rsp_cnt = 0;
  logic [7:0] m_ks = 8'h00, m_pend_byte = 8'h00;
  logic       s_key, s_dat;
  logic [7:0] s_d;

  trivium_ctrl dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ds_afull(ds_afull), .core_key(core_key), .core_strob_key(core_strob_key),
    .core_data(core_data), .core_strob_data(core_strob_data),
    .core_fifo_cnd(core_fifo_cnd), .core_stream(core_stream),
    .core_wt_sgn(core_wt_sgn), .core_status(core_status),
    .ctrl_state(ctrl_state), .fault(fault), .byte_cnt(byte_cnt)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] ks_step(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // Behavioural cipher core: init delay after the key strobe, fixed 3-cycle
  // response latency, keystream from a small LFSR reseeded on each key load.
  always @(posedge clk) begin
    s_key = core_strob_key;
    s_dat = core_strob_data;
    s_d   = core_data;
    #1;
    core_wt_sgn = 1'b0;
    if (!rst) begin
      m_keyed = 1'b0; m_init_cnt = 0; m_pend = 1'b0;
      core_status = 8'h00; core_stream = 8'h00;
    end else begin
      if (s_key) begin
        m_keyed = 1'b1; m_init_cnt = 0; m_ks = KS_SEED; m_pend = 1'b0;
      end else if (m_keyed && m_init_cnt < INIT_DELAY) begin
        m_init_cnt++;
      end
      if (m_pend) begin
        if (m_rsp_cnt == 1) begin
          core_wt_sgn = 1'b1; core_stream = m_pend_byte; m_pend = 1'b0;
        end else begin
          m_rsp_cnt--;
        end
      end
      if (s_dat && !m_no_rsp) begin
        m_pend = 1'b1; m_rsp_cnt = 2; m_pend_byte = s_d ^ m_ks; m_ks = ks_step(m_ks);
      end
      core_status = {6'b0, m_blk,
                     m_keyed && (m_init_cnt >= INIT_DELAY) && !m_never_init && !m_blk};
    end
  end

  task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ctrl_state == st) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (ctrl_state !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d expected 0", ctrl_state); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b expected 0", fault); end
    n_cmp++; if (byte_cnt !== 16'h0) begin n_err++; $display("FAIL rst_byte_cnt: got %h expected 0", byte_cnt); end
    n_cmp++; if (core_fifo_cnd !== 2'b00) begin n_err++; $display("FAIL rst_fifo_cnd: got %b expected 00", core_fifo_cnd); end
    n_cmp++; if ({core_strob_key, core_key, core_strob_data, in_ready, out_valid} !== 5'b0) begin
      n_err++; $display("FAIL rst_strobes: got %b expected 00000", {core_strob_key, core_key, core_strob_data, in_ready, out_valid});
    end
    ds_afull = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); ds_afull = 1'b1; #1;
    n_cmp++; if (core_fifo_cnd !== 2'b01) begin n_err++; $display("FAIL idle_afull_cnd: got %b expected 01", core_fifo_cnd); end
    ds_afull = 1'b0; #1;
    n_cmp++; if (core_fifo_cnd !== 2'b00) begin n_err++; $display("FAIL idle_open_cnd: got %b expected 00", core_fifo_cnd); end
  endtask

  task automatic test_key_load();
    logic [79:0] k;
    logic        exp_b;
    int          n;
    k = KEY_A;
    @(negedge clk); key_in = k; key_load = 1'b1;
    @(negedge clk); key_load = 1'b0;
    n_cmp++; if (ctrl_state !== 3'd1) begin n_err++; $display("FAIL load_state: got %0d expected 1", ctrl_state); end
    n = 0;
    while (core_strob_key === 1'b1 && n < 200) begin
      exp_b = (n < 80) ? k[79-n] : 1'b0;
      n_cmp++; if (core_key !== exp_b) begin n_err++; $display("FAIL key_bit[%0d]: got %b expected %b", n, core_key, exp_b); end
      n++;
      @(negedge clk);
    end
    n_cmp++; if (n != 81) begin n_err++; $display("FAIL strobe_len: got %0d expected 81", n); end
    n_cmp++; if (ctrl_state !== 3'd2) begin n_err++; $display("FAIL after_load_state: got %0d expected 2", ctrl_state); end
  endtask

  task automatic test_stream();
    logic [7:0] pat[3];
    logic [7:0] exp;
    bit         ok, got;
    pat = '{8'h00, 8'hFF, 8'hA5};
    wait_state(3'd3, 3000, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL init_to_run: got timeout expected RUN"); end
    exp_ks = KS_SEED;
    out_ready = 1'b1;
    foreach (pat[i]) begin
      in_data = pat[i]; in_valid = 1'b1; got = 1'b0;
      for (int t = 0; t < 50; t++) begin
        #1;
        if (in_ready === 1'b1) begin
          got = 1'b1; sb_q.push_back(pat[i] ^ exp_ks); exp_ks = ks_step(exp_ks);
          break;
        end
        @(negedge clk);
      end
      @(negedge clk); in_valid = 1'b0;
      for (int t = 0; t < 50 && got; t++) begin
        #1;
        if (out_valid === 1'b1) break;
        @(negedge clk);
      end
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hXX;
      n_cmp++; if (!got || out_valid !== 1'b1 || out_data !== exp) begin
        n_err++; $display("FAIL stream_byte[%0d]: got valid=%b data=%h expected data=%h", i, out_valid, out_data, exp);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (byte_cnt !== 16'd3) begin n_err++; $display("FAIL stream_byte_cnt: got %0d expected 3", byte_cnt); end
  endtask

  task automatic test_backpressure();
    int         pulses, unstable;
    bit         seen;
    logic [7:0] first, exp;
    pulses = 0; unstable = 0; seen = 1'b0; first = 8'h00;
    @(negedge clk);
    out_ready = 1'b0; in_data = 8'h3C; in_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (in_ready === 1'b1) begin
        pulses++; sb_q.push_back(in_data ^ exp_ks); exp_ks = ks_step(exp_ks);
      end
      if (out_valid === 1'b1) begin
        if (!seen) begin seen = 1'b1; first = out_data; end
        else if (out_data !== first) unstable++;
      end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL bp_in_ready_pulses: got %0d expected 1", pulses); end
    n_cmp++; if (unstable != 0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_hold: got unstable=%0d valid=%b expected 0 and 1", unstable, out_valid);
    end
    n_cmp++; if (core_fifo_cnd !== 2'b01) begin n_err++; $display("FAIL bp_fifo_cnd: got %b expected 01", core_fifo_cnd); end
    in_valid = 1'b0; out_ready = 1'b1;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hXX;
    n_cmp++; if (out_data !== exp) begin n_err++; $display("FAIL bp_data: got %h expected %h", out_data, exp); end
    @(negedge clk); #1;
    n_cmp++; if (byte_cnt !== 16'd4) begin n_err++; $display("FAIL bp_byte_cnt: got %0d expected 4", byte_cnt); end
    n_cmp++; if (core_fifo_cnd !== 2'b00) begin n_err++; $display("FAIL bp_fifo_cnd_clear: got %b expected 00", core_fifo_cnd); end
  endtask

  task automatic test_hold();
    int pulses;
    pulses = 0;
    @(negedge clk); m_blk = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (ctrl_state !== 3'd4) begin n_err++; $display("FAIL hold_state: got %0d expected 4", ctrl_state); end
    in_data = 8'h11; in_valid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      #1;
      if (in_ready === 1'b1) pulses++;
      @(negedge clk);
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL hold_no_issue: got %0d expected 0", pulses); end
    in_valid = 1'b0; m_blk = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (ctrl_state !== 3'd3) begin n_err++; $display("FAIL hold_resume: got %0d expected 3", ctrl_state); end
  endtask

  task automatic test_keyload_wt();
    bit got;
    @(negedge clk); in_data = 8'h77; in_valid = 1'b1; got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (in_ready === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk); in_valid = 1'b0;
    for (int t = 0; t < 20 && got; t++) begin
      #1;
      if (core_wt_sgn === 1'b1) break;
      @(negedge clk);
    end
    n_cmp++; if (!got || core_wt_sgn !== 1'b1) begin
      n_err++; $display("FAIL kw_response: got issue=%b wt_sgn=%b expected 1 and 1", got, core_wt_sgn);
    end
    key_in = KEY_A; key_load = 1'b1;
    @(negedge clk); key_load = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL kw_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (ctrl_state !== 3'd1) begin n_err++; $display("FAIL kw_state: got %0d expected 1", ctrl_state); end
    n_cmp++; if (byte_cnt !== 16'd0) begin n_err++; $display("FAIL kw_byte_cnt: got %0d expected 0", byte_cnt); end
  endtask

  task automatic test_init_timeout();
    bit ok;
    int cnt;
    m_never_init = 1'b1;
    wait_state(3'd2, 200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL to_reach_wait: got timeout expected WAIT_INIT"); end
    cnt = 1;
    while (cnt < 3000) begin
      @(negedge clk);
      if (ctrl_state != 3'd2) break;
      cnt++;
    end
    #1;
    n_cmp++; if (cnt != 2047) begin n_err++; $display("FAIL init_timeout_cycles: got %0d expected 2047", cnt); end
    n_cmp++; if (ctrl_state !== 3'd5 || fault !== 1'b1) begin
      n_err++; $display("FAIL init_fault: got state=%0d fault=%b expected 5 and 1", ctrl_state, fault);
    end
    in_data = 8'h99; in_valid = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    n_cmp++; if (fault !== 1'b1 || in_ready !== 1'b0 || core_strob_data !== 1'b0) begin
      n_err++; $display("FAIL fault_sticky: got fault=%b in_ready=%b strobe=%b expected 1 0 0", fault, in_ready, core_strob_data);
    end
    in_valid = 1'b0; m_never_init = 1'b0;
    @(negedge clk); key_in = KEY_A; key_load = 1'b1;
    @(negedge clk); key_load = 1'b0; #1;
    n_cmp++; if (ctrl_state !== 3'd1 || fault !== 1'b0) begin
      n_err++; $display("FAIL fault_recover: got state=%0d fault=%b expected 1 and 0", ctrl_state, fault);
    end
  endtask

  task automatic test_rsp_timeout();
    bit ok, got;
    int n;
    wait_state(3'd3, 3000, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rsp_reach_run: got timeout expected RUN"); end
    m_no_rsp = 1'b1; in_data = 8'h42; in_valid = 1'b1; got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (in_ready === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk); in_valid = 1'b0; n = 1;
    while (ctrl_state != 3'd5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (!got || n != 16) begin n_err++; $display("FAIL rsp_timeout_cycles: got %0d expected 16", n); end
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL rsp_fault: got %b expected 1", fault); end
    m_no_rsp = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk); key_in = KEY_A; key_load = 1'b1;
    @(negedge clk); key_load = 1'b0;
    repeat (39) @(negedge clk);
    #2;
    n_cmp++; if (core_strob_key !== 1'b1) begin n_err++; $display("FAIL mid_load_strobe: got %b expected 1", core_strob_key); end
    rst = 1'b0;
    #1;
    n_cmp++; if (core_strob_key !== 1'b0) begin n_err++; $display("FAIL async_strobe_drop: got %b expected 0", core_strob_key); end
    n_cmp++; if (ctrl_state !== 3'd0 || fault !== 1'b0) begin
      n_err++; $display("FAIL async_state: got state=%0d fault=%b expected 0 and 0", ctrl_state, fault);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; key_load = 1'b0; key_in = '0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; ds_afull = 1'b1;
    exp_ks = KS_SEED;
    test_reset();
    test_key_load();
    test_stream();
    test_backpressure();
    test_hold();
    test_keyload_wt();
    test_init_timeout();
    test_rsp_timeout();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
